// File: rtl/flash_if_pkg.sv
// Shared definitions for the pipelined Wishbone flash read port: FSM encoding,
// request-entry layout helpers and timer sizing.
package flash_if_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam int WE_WIDTH = 1;

    // A request entry is packed as {we, sel, adr} with adr in the low bits.
    function automatic int entry_width(input int addr_width, input int sel_width);
        return addr_width + sel_width + WE_WIDTH;
    endfunction

    function automatic int sel_offset(input int addr_width);
        return addr_width;
    endfunction

    function automatic int we_offset(input int addr_width, input int sel_width);
        return addr_width + sel_width;
    endfunction

    function automatic int timer_width(input int timeout_cycles);
        return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/flash_req_fifo.sv
// Synchronous request FIFO with a flush input; full is registered so it can
// drive the Wishbone stall line directly.
module flash_req_fifo
    import flash_if_pkg::*;
#(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             full_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && (count != '0);

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count  <= count_next;
            full_q <= (count_next == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = full_q;

endmodule

// File: rtl/wb_flash_pipelined_read_port.sv
// Pipelined Wishbone slave in front of the flash cache: queued reads, in-order acks,
// busy timeout and cyc-drop abort. Optional macro: WB_FLASH_WRITE_ERROR_EN.
module wb_flash_pipelined_read_port
    import flash_if_pkg::*;
#(
    parameter  int ADDR_WIDTH     = 24,
    parameter  int DATA_WIDTH     = 32,
    parameter  int REQ_DEPTH      = 4,
    parameter  int TIMEOUT_CYCLES = 1023,
    localparam int SEL_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [SEL_WIDTH-1:0]  wb_sel_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    output logic                  wb_ack_o,
    output logic                  wb_stall_o,
    output logic                  wb_error_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic                  flashCache_readEnable,
    output logic [ADDR_WIDTH-1:0] flashCache_address,
    output logic [SEL_WIDTH-1:0]  flashCache_byteSelect,
    input  logic [DATA_WIDTH-1:0] flashCache_dataRead,
    input  logic                  flashCache_busy
);

    localparam int ENTRY_W     = entry_width(ADDR_WIDTH, SEL_WIDTH);
    localparam int SEL_OFFSET  = sel_offset(ADDR_WIDTH);
    localparam int WE_OFFSET   = we_offset(ADDR_WIDTH, SEL_WIDTH);
    localparam int TIMER_WIDTH = timer_width(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
        TIMEOUT_EN ? TIMER_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = '1;

    state_t                 state;
    state_t                 state_next;
    logic [ENTRY_W-1:0]     push_entry;
    logic [ENTRY_W-1:0]     head;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   accept;
    logic                   pop;
    logic                   head_we;
    logic [ADDR_WIDTH-1:0]  cur_adr;
    logic [SEL_WIDTH-1:0]   cur_sel;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   timeout_hit;
    logic                   ack_next;
    logic                   err_next;
    logic [DATA_WIDTH-1:0]  data_next;
    logic                   ack_q;
    logic                   err_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   unused_write_data;

    // Flash is read-only, so write data never goes anywhere.
    assign unused_write_data = ^wb_data_i;

    assign accept     = wb_cyc_i && wb_stb_i && !fifo_full;
    assign push_entry = {wb_we_i, wb_sel_i, wb_adr_i};
    assign head_we    = head[WE_OFFSET];

    flash_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk       (wb_clk_i),
        .reset     (wb_rst_i),
        .flush     (!wb_cyc_i),
        .push      (accept),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign timeout_hit = TIMEOUT_EN && (timer == TIMER_LAST);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        data_next  = '0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_we) begin
                        state_next = RESPOND;
`ifdef WB_FLASH_WRITE_ERROR_EN
                        err_next   = 1'b1;
`else
                        ack_next   = 1'b1;
`endif
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                if (!flashCache_busy) begin
                    state_next = RESPOND;
                    ack_next   = 1'b1;
                    data_next  = flashCache_dataRead;
                end else if (timeout_hit) begin
                    state_next = RESPOND;
                    err_next   = 1'b1;
                end
            end
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Dropping cyc abandons everything, including a response about to be issued.
        if (!wb_cyc_i) begin
            state_next = IDLE;
            pop        = 1'b0;
            ack_next   = 1'b0;
            err_next   = 1'b0;
            data_next  = '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            cur_adr <= '0;
            cur_sel <= '0;
            timer   <= '0;
        end else begin
            state  <= state_next;
            ack_q  <= ack_next;
            err_q  <= err_next;
            data_q <= data_next;
            if (pop) begin
                cur_adr <= head[ADDR_WIDTH-1:0];
                cur_sel <= head[SEL_OFFSET +: SEL_WIDTH];
            end
            if (state == READ && state_next == READ) begin
                timer <= (timer == TIMER_MAX) ? timer : timer + 1'b1;
            end else begin
                timer <= '0;
            end
        end
    end

    assign wb_ack_o              = ack_q;
    assign wb_error_o            = err_q;
    assign wb_data_o             = data_q;
    assign wb_stall_o            = fifo_full;
    assign flashCache_readEnable = (state == READ);
    assign flashCache_address    = (state == READ) ? cur_adr : '0;
    assign flashCache_byteSelect = (state == READ) ? cur_sel : '0;

endmodule
